// File: rtl/dma_pkg.sv
// Shared encodings, region map and FSM states for the DMA transfer sequencer.
// Region/opcode checking in the sequencer is enabled by DMA_SEQ_ERRCHK_EN.
package dma_pkg;

  localparam int INSTR_W = 26;
  localparam int OP_HI   = 25;
  localparam int OP_LO   = 24;
  localparam int DIR_HI  = 23;
  localparam int DIR_LO  = 22;
  localparam int SRC_HI  = 21;
  localparam int SRC_LO  = 14;
  localparam int DST_HI  = 13;
  localparam int DST_LO  = 6;
  localparam int CNT_HI  = 5;
  localparam int CNT_LO  = 0;

  localparam int MEM_LO = 0;
  localparam int MEM_HI = 191;
  localparam int IO1_LO = 192;
  localparam int IO1_HI = 223;
  localparam int IO2_LO = 224;
  localparam int IO2_HI = 255;

  typedef enum logic [1:0] {
    OP_INC     = 2'b00,
    OP_DST_FIX = 2'b01,
    OP_SRC_FIX = 2'b10,
    OP_ILL     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    DIR_ILL0    = 2'b00,
    DIR_SRC_MEM = 2'b01,
    DIR_DST_MEM = 2'b10,
    DIR_ILL3    = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    RG_MEM,
    RG_IO1,
    RG_IO2
  } region_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;

  // Offset of the last address inside a region.
  function automatic int region_span(region_e r);
    case (r)
      RG_IO1:  return IO1_HI - IO1_LO;
      RG_IO2:  return IO2_HI - IO2_LO;
      default: return MEM_HI - MEM_LO;
    endcase
  endfunction

endpackage

// File: rtl/dma_region_decode.sv
// Combinational address decoder: region select plus offset into that region.
// Used for both source and destination address paths of the sequencer.
module dma_region_decode
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8
)(
  input  logic [ADDR_W-1:0] addr,
  output region_e           region,
  output logic [ADDR_W-1:0] offset
);

  always_comb begin
    region = RG_MEM;
    offset = addr;
    unique case (1'b1)
      (addr <= ADDR_W'(MEM_HI)): begin
        region = RG_MEM;
        offset = addr - ADDR_W'(MEM_LO);
      end
      (addr >= ADDR_W'(IO1_LO) && addr <= ADDR_W'(IO1_HI)): begin
        region = RG_IO1;
        offset = addr - ADDR_W'(IO1_LO);
      end
      (addr >= ADDR_W'(IO2_LO)): begin
        region = RG_IO2;
        offset = addr - ADDR_W'(IO2_LO);
      end
    endcase
  end

endmodule

// File: rtl/dma_xfer_sequencer.sv
// DMA transfer sequencer: instruction handshake, bus request, read/write beats.
// Define DMA_SEQ_ERRCHK_EN to enable opcode/direction/region-crossing checks.
module dma_xfer_sequencer
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
)(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               busybus,
  input  logic               grant,
  output logic [ADDR_W-1:0]  bus_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  wr_data,
  output logic               mem_we,
  output logic               io1_we,
  output logic               io2_we,
  output logic [CNT_W-1:0]   remaining,
  output logic               done,
  output logic               err
);

  state_e            state, nxt;
  op_e               op_q, in_op;
  dir_e              in_dir;
  region_e           src_reg, dst_reg;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic [ADDR_W-1:0] src_a, dst_a;
  logic [ADDR_W-1:0] src_off, dst_off;
  logic [CNT_W-1:0]  in_cnt;
  logic              accept, src_inc, dst_inc;
  logic              last, bad_instr, step_err;

  assign in_op   = op_e'(instr[OP_HI:OP_LO]);
  assign in_dir  = dir_e'(instr[DIR_HI:DIR_LO]);
  assign in_cnt  = CNT_W'(instr[CNT_HI:CNT_LO]);
  assign accept  = instr_valid && instr_ready;
  assign src_inc = (op_q != OP_SRC_FIX);
  assign dst_inc = (op_q != OP_DST_FIX);
  assign last    = (remaining == CNT_W'(1));

  // In IDLE the decoders look at the offered instruction for the accept check.
  assign src_a = (state == S_IDLE) ?
                 ADDR_W'(instr[SRC_HI:SRC_LO]) : cur_src;
  assign dst_a = (state == S_IDLE) ?
                 ADDR_W'(instr[DST_HI:DST_LO]) : cur_dst;

  dma_region_decode #(.ADDR_W(ADDR_W)) u_src_dec (
    .addr   (src_a),
    .region (src_reg),
    .offset (src_off)
  );

  dma_region_decode #(.ADDR_W(ADDR_W)) u_dst_dec (
    .addr   (dst_a),
    .region (dst_reg),
    .offset (dst_off)
  );

`ifdef DMA_SEQ_ERRCHK_EN
  assign bad_instr = (in_op == OP_ILL) ||
    !((in_dir == DIR_SRC_MEM && src_reg == RG_MEM) ||
      (in_dir == DIR_DST_MEM && dst_reg == RG_MEM));
  // Next step would leave the current region on an incrementing side.
  assign step_err =
    (src_inc && src_off == ADDR_W'(region_span(src_reg))) ||
    (dst_inc && dst_off == ADDR_W'(region_span(dst_reg)));
`else
  logic unused_chk;
  assign bad_instr  = 1'b0;
  assign step_err   = 1'b0;
  assign unused_chk = ^{in_dir, src_reg, src_off, dst_off};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt         = state;
    instr_ready = 1'b0;
    busybus     = 1'b0;
    bus_addr    = '0;
    mem_we      = 1'b0;
    io1_we      = 1'b0;
    io2_we      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (bad_instr)            nxt = S_ERR;
          else if (in_cnt == '0)    nxt = S_DONE;
          else                      nxt = S_REQ;
        end
      end
      S_REQ: begin
        busybus = 1'b1;
        if (grant) nxt = S_RD;
      end
      S_RD: begin
        busybus  = 1'b1;
        bus_addr = cur_src;
        nxt      = grant ? S_WR : S_REQ;
      end
      S_WR: begin
        busybus  = 1'b1;
        bus_addr = cur_dst;
        unique case (dst_reg)
          RG_IO1:  io1_we = 1'b1;
          RG_IO2:  io2_we = 1'b1;
          default: mem_we = 1'b1;
        endcase
        if (last)          nxt = S_DONE;
        else if (step_err) nxt = S_ERR;
        else if (!grant)   nxt = S_REQ;
        else               nxt = S_RD;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_INC;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      wr_data   <= '0;
    end else begin
      if (accept) begin
        op_q      <= (in_op == OP_ILL) ? OP_INC : in_op;
        cur_src   <= ADDR_W'(instr[SRC_HI:SRC_LO]);
        cur_dst   <= ADDR_W'(instr[DST_HI:DST_LO]);
        remaining <= in_cnt;
      end
      if (state == S_RD && grant) begin
        wr_data <= rd_data;
      end
      if (state == S_WR) begin
        remaining <= remaining - CNT_W'(1);
        if (src_inc) cur_src <= cur_src + ADDR_W'(1);
        if (dst_inc) cur_dst <= cur_dst + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Scoreboard bench for dma_xfer_sequencer: directed cases plus random traffic.
// Expected beats come from an address-walk model; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_dma_xfer_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic [25:0]       instr = '0;
  logic              instr_ready;
  logic              busybus;
  logic              grant = 1'b0;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_data;
  logic              mem_we, io1_we, io2_we;
  logic [CNT_W-1:0]  remaining;
  logic              done, err;

  dma_xfer_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .busybus(busybus),
    .grant(grant), .bus_addr(bus_addr),
    .rd_data(rd_data), .wr_data(wr_data),
    .mem_we(mem_we), .io1_we(io1_we), .io2_we(io2_we),
    .remaining(remaining), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_end;
    bit         is_err;
    logic [7:0] addr;
    logic [31:0] data;
    int         kind;
    int         rem;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  busy_rises = 0, busy_cyc = 0;
  int  ends_seen = 0, end_cyc = 0;
  int  writes_seen = 0, issue_cyc = 0;
  int  gmode = 0;
  bit  prev_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory/peripheral contents seen by the read beat.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a ^ 8'hA5, ~a, a + 8'd7, a};
  endfunction

  assign rd_data = mem_word(bus_addr);

  function automatic int region_of(input int a);
    if (a < 192) return 0;
    if (a < 224) return 1;
    return 2;
  endfunction

  function automatic logic [25:0] mk(input int op, input int dir,
                                     input int s, input int d,
                                     input int n);
    logic [1:0] o2, d2;
    logic [7:0] s8, d8;
    logic [5:0] n6;
    o2 = 2'(op); d2 = 2'(dir); s8 = 8'(s); d8 = 8'(d); n6 = 6'(n);
    return {o2, d2, s8, d8, n6};
  endfunction

  task automatic check(input string name, input longint act,
                       input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d", name, act);
  endtask

  task automatic push_end(input bit is_err);
    ev_t e;
    e = '{is_end: 1'b1, is_err: is_err, addr: 8'd0,
          data: 32'd0, kind: 0, rem: 0};
    exp_q.push_back(e);
  endtask

  // Reference: walk addresses word by word from the instruction fields.
  task automatic push_expect(input logic [25:0] ins);
    int  op, dir, s, d, n, ns, nd;
    ev_t e;
    op  = int'(ins[25:24]);
    dir = int'(ins[23:22]);
    s   = int'(ins[21:14]);
    d   = int'(ins[13:6]);
    n   = int'(ins[5:0]);
`ifdef DMA_SEQ_ERRCHK_EN
    if (op == 3 || !((dir == 1 && region_of(s) == 0) ||
                     (dir == 2 && region_of(d) == 0))) begin
      push_end(1'b1);
      return;
    end
`else
    if (op == 3) op = 0;
    if (dir < 0) op = 0;
`endif
    for (int i = 0; i < n; i++) begin
      e = '{is_end: 1'b0, is_err: 1'b0, addr: 8'(d),
            data: mem_word(8'(s)), kind: region_of(d), rem: n - i};
      exp_q.push_back(e);
      if (i == n - 1) break;
      ns = (op == 2) ? s : (s + 1) % 256;
      nd = (op == 1) ? d : (d + 1) % 256;
`ifdef DMA_SEQ_ERRCHK_EN
      if (region_of(ns) != region_of(s) ||
          region_of(nd) != region_of(d)) begin
        push_end(1'b1);
        return;
      end
`endif
      s = ns;
      d = nd;
    end
    push_end(1'b0);
  endtask

  initial begin : grant_drv
    int beats, drop_left;
    beats = 0;
    drop_left = 0;
    forever begin
      @(negedge clock);
      if (gmode != 2) beats = 0;
      else if (mem_we || io1_we || io2_we) begin
        beats++;
        if (beats == 2) drop_left = 3;
      end
      if (drop_left > 0) begin
        grant = 1'b0;
        drop_left--;
      end else if (gmode == 1) begin
        grant = ($urandom_range(0, 3) != 0);
      end else begin
        grant = 1'b1;
      end
    end
  end

  initial begin : monitor
    int  nwe, kind;
    ev_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_busy = 1'b0;
      end else begin
        if (busybus && !prev_busy) begin
          busy_rises++;
          busy_cyc = cyc;
        end
        prev_busy = busybus;
        nwe = int'(mem_we) + int'(io1_we) + int'(io2_we);
        if (nwe != 0) begin
          writes_seen++;
          check("strobe_onehot", nwe, 1);
          if (exp_q.size() == 0 || exp_q[0].is_end) begin
            fail_now("unexpected_write", longint'(bus_addr));
          end else begin
            e = exp_q.pop_front();
            kind = io1_we ? 1 : (io2_we ? 2 : 0);
            check("wr_addr", longint'(bus_addr), longint'(e.addr));
            check("wr_data", longint'(wr_data), longint'(e.data));
            check("wr_region", kind, e.kind);
            check("wr_remaining", longint'(remaining), e.rem);
          end
        end
        if (done || err) begin
          ends_seen++;
          end_cyc = cyc;
          check("end_busybus", longint'(busybus), 0);
          if (exp_q.size() == 0 || !exp_q[0].is_end) begin
            fail_now("unexpected_end", longint'({done, err}));
          end else begin
            e = exp_q.pop_front();
            check("end_done_err", longint'({done, err}),
                  e.is_err ? 1 : 2);
            if (!e.is_err)
              check("done_remaining", longint'(remaining), 0);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    instr_valid = 1'b0;
    repeat (3) @(negedge clock);
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic issue(input logic [25:0] ins);
    int t;
    t = 0;
    push_expect(ins);
    @(negedge clock);
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!instr_ready) fail_now("ready_timeout", t);
    issue_cyc = cyc;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_end(input int target);
    int t;
    t = 0;
    while (ends_seen < target && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (ends_seen < target) begin
      fail_now("end_timeout", t);
      apply_reset();
    end
  endtask

  task automatic run(input logic [25:0] ins);
    int target;
    target = ends_seen + 1;
    issue(ins);
    wait_end(target);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, w0, e0, t;
    logic [25:0] ins;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busybus", longint'(busybus), 0);
    check("rst_strobes", longint'({mem_we, io1_we, io2_we}), 0);
    check("rst_done_err", longint'({done, err}), 0);
    check("rst_bus_addr", longint'(bus_addr), 0);
    check("rst_wr_data", longint'(wr_data), 0);
    check("rst_remaining", longint'(remaining), 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready", longint'(instr_ready), 1);

    gmode = 0;
    b0 = busy_rises;
    run(mk(0, 1, 10, 192, 3));
    check("lat_cnt3", end_cyc - busy_cyc, 7);
    check("busy_once_cnt3", busy_rises - b0, 1);

    run(mk(1, 1, 0, 224, 2));

    b0 = busy_rises;
    run(mk(0, 1, 30, 40, 0));
    check("cnt0_done_lat", end_cyc - issue_cyc, 1);
    check("cnt0_no_busy", busy_rises - b0, 0);

    gmode = 2;
    b0 = busy_rises;
    w0 = writes_seen;
    run(mk(0, 1, 40, 80, 4));
    check("drop_writes", writes_seen - w0, 4);
    check("drop_lat", end_cyc - busy_cyc, 12);
    check("drop_busy_once", busy_rises - b0, 1);
    gmode = 0;

    run(mk(0, 1, 190, 200, 4));
    b0 = busy_rises;
    run(mk(0, 3, 5, 6, 1));
`ifdef DMA_SEQ_ERRCHK_EN
    check("dir11_err_lat", end_cyc - issue_cyc, 1);
    check("dir11_no_busy", busy_rises - b0, 0);
`endif

    e0 = ends_seen;
    @(negedge clock);
    instr = mk(0, 1, 20, 100, 5);
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    t = 0;
    while (!(busybus && bus_addr == 8'd20) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) fail_now("rd_wait_timeout", t);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busybus", longint'(busybus), 0);
    check("arst_bus_addr", longint'(bus_addr), 0);
    check("arst_wr_data", longint'(wr_data), 0);
    check("arst_remaining", longint'(remaining), 0);
    check("arst_strobes", longint'({mem_we, io1_we, io2_we}), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("arst_ready", longint'(instr_ready), 1);
    check("arst_no_end", ends_seen - e0, 0);

    gmode = 1;
    for (int k = 0; k < 80; k++) begin
      ins = mk($urandom_range(0, 3),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3)
                                           : $urandom_range(1, 2),
               $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 12));
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run(ins);
    end

    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
